load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 0: the number of extra cycles the block holds the memory port before committing (0..15).
REQ-002 The block SHALL have parameter ADDR_LIMIT, default 32768: the data memory size in bytes; addresses at or beyond it are out of range.
REQ-003 clk  in  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset; asynchronous and active-low.
REQ-005 req_valid  in  1  the pipeline presents a request.
REQ-006 req_ready  out  1  the block accepts the request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  bytes-1 (3 = word, 1 = halfword, 0 = byte, 2 = invalid).
REQ-009 req_signed  in  1  load result is sign-extended (1) or zero-extended (0).
REQ-010 req_addr  in  32  byte address; bit 0 is the MSB throughout the block.
REQ-011 req_wdata  in  32  store data, right-justified.
REQ-012 resp_valid  out  1  the response is available.
REQ-013 resp_ready  in  1  the pipeline consumes the response.
REQ-014 resp_rdata  out  32  the extended load data; 0 for stores and errors.
REQ-015 resp_err  out  1  the request was rejected (misaligned, invalid size or out of range).
REQ-016 mem_addr / mem_wdata  out  32 / 32  data memory address and write data.
REQ-017 mem_we  out  1  data memory write enable (memory writes on the rising edge).
REQ-018 mem_dsize  out  2  data memory size code, same encoding as req_size.
REQ-019 mem_rdata  in  32  combinational memory read; the byte at mem_addr is in bits [0:7].

Function
REQ-020 The FSM SHALL have exactly the states IDLE, ACCESS and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a transfer occurs on any rising edge with req_valid & req_ready.
REQ-022 On a transfer, the block SHALL register the request fields and check the request:
- error if req_size = 2;
- error if size 1 and addr[31] = 1;
- error if size 3 and addr[30:31] != 0;
- error if addr + size >= ADDR_LIMIT.
REQ-023 An erroring request SHALL go IDLE -> RESP with resp_err = 1 and resp_rdata = 0, and SHALL never assert mem_we.
REQ-024 A valid request SHALL go IDLE -> ACCESS, where mem_addr, mem_dsize and mem_wdata stay stable for WAIT_CYCLES+1 cycles, counted by a wait counter.
REQ-025 In the final ACCESS cycle of a store, mem_we SHALL be 1; mem_we SHALL be 1 for exactly one cycle per store and 0 at all other times.
REQ-026 In the final ACCESS cycle of a load, the block SHALL capture mem_rdata on the rising edge. The result is:
- word: mem_rdata[0:31];
- halfword: mem_rdata[0:15], extended to 32 bits;
- byte: mem_rdata[0:7], extended to 32 bits;
- extension is with bit 0 of the field if req_signed = 1, otherwise with zeros.
REQ-027 After the final ACCESS cycle, the FSM SHALL go to RESP with resp_err = 0.
REQ-028 Latency: resp_valid SHALL rise WAIT_CYCLES+1 edges after acceptance for valid requests, and 1 edge after acceptance for errors.
REQ-029 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready = 1. On that edge the FSM goes to IDLE, so the block does not accept a new request in the same cycle.
REQ-030 Outside ACCESS, mem_addr, mem_wdata and mem_dsize SHALL hold their last values and mem_we SHALL be 0.
REQ-031 Address arithmetic SHALL be 32-bit unsigned; no wrap past ADDR_LIMIT is permitted (such requests are errors).

Reset
REQ-032 While rst_n = 0, regardless of the clock:
- state = IDLE, wait counter = 0;
- req_ready = 0, resp_valid = 0, resp_err = 0, mem_we = 0;
- resp_rdata, mem_addr, mem_wdata = 0; mem_dsize = 0.
REQ-033 When rst_n is asserted mid-ACCESS or mid-RESP, the block SHALL drop the pending transaction and write nothing. After the first rising edge with rst_n = 1, req_ready SHALL be 1.

Verification
REQ-034 Word load, WAIT_CYCLES=0, mem[0x2000..0x2003] = 12 34 56 78 -> resp_valid 1 edge after acceptance, rdata 0x12345678, err 0, mem_we never high.
REQ-035 Signed byte load at 0x2001 holding 0x9A -> rdata 0xFFFFFF9A; the same load unsigned -> 0x0000009A; signed halfword 0x8001 -> 0xFFFF8001.
REQ-036 Halfword store of wdata 0xAAAABEEF at 0x2002, WAIT_CYCLES=3 -> mem_we high for exactly one cycle, 4 edges after acceptance, with mem_dsize=1; memory then reads BE EF; resp_rdata 0.
REQ-037 Each of the following -> err 1 one edge after acceptance, mem_we never high:
- word at 0x2002;
- halfword at 0x2003;
- size 2;
- word at ADDR_LIMIT-2.
REQ-038 resp_ready held 0 for 5 cycles -> resp_valid and data stable and req_ready 0 throughout; resp_ready high for one edge -> IDLE on the next cycle.
REQ-039 rst_n pulled low during ACCESS of a store with WAIT_CYCLES=2 -> mem_we 0 immediately, memory unchanged, req_ready 1 one edge after release.

Source files
------------

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// Single-outstanding load/store unit between a pipeline request/response
// handshake and a synchronous-write, combinational-read data memory.
// Requests are checked for size, alignment and range. Good requests hold
// the memory port for WAIT_CYCLES+1 cycles before committing. Bad requests
// go straight to a response with resp_err set. All vectors are big-endian
// numbered: bit 0 is the MSB. The byte at mem_addr occupies bits [0:7] of
// both mem_rdata and mem_wdata.
//
// Parameters
//   WAIT_CYCLES  extra cycles the memory port is held before commit (0..15)
//   ADDR_LIMIT   data memory size in bytes; addresses at or beyond it fail
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_write                  1 = store, 0 = load
//   req_size                   bytes-1 (0 byte, 1 halfword, 3 word, 2 invalid)
//   req_signed                 sign-extend load data
//   req_addr                   byte address
//   req_wdata                  store data, right-justified
//   resp_valid / resp_ready    response handshake
//   resp_rdata                 extended load data (0 for stores and errors)
//   resp_err                   request was rejected
//   mem_addr, mem_wdata        memory address and left-justified write data
//   mem_we                     memory write enable, one cycle per store
//   mem_dsize                  memory size code, same encoding as req_size
//   mem_rdata                  combinational memory read data
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_LIMIT  = 32768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [0:1]  req_size,
    input  logic        req_signed,
    input  logic [0:31] req_addr,
    input  logic [0:31] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [0:31] resp_rdata,
    output logic        resp_err,
    output logic [0:31] mem_addr,
    output logic [0:31] mem_wdata,
    output logic        mem_we,
    output logic [0:1]  mem_dsize,
    input  logic [0:31] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [0:3]  wait_cnt;
    logic        wait_last;
    logic        transfer;
    logic        req_error;
    logic [0:32] addr_end;
    logic        write_q;
    logic        signed_q;
    logic [0:1]  size_q;
    logic [0:31] load_data;
    logic [0:31] store_lane;

    assign transfer  = req_valid & req_ready;
    assign wait_last = (wait_cnt == 4'(WAIT_CYCLES));

    // Address of the last byte touched, in 33 bits so that a request near
    // the top of the 32-bit space cannot wrap back into range.
    assign addr_end = {1'b0, req_addr} + {31'b0, req_size};

    assign req_error = (req_size == 2'd2)
                     | ((req_size == 2'd1) & req_addr[31])
                     | ((req_size == 2'd3) & (req_addr[30:31] != 2'b00))
                     | (addr_end >= 33'(ADDR_LIMIT));

    // Store data arrives right-justified; the memory expects the byte at
    // mem_addr in the top lane, so narrow stores are shifted up.
    always_comb begin
        store_lane = req_wdata;
        case (req_size)
            2'd0:    store_lane = {req_wdata[24:31], 24'h0};
            2'd1:    store_lane = {req_wdata[16:31], 16'h0};
            default: store_lane = req_wdata;
        endcase
    end

    // Load data sits in the top lane; narrow loads are extended with the
    // field's own MSB when signed, otherwise with zeros.
    always_comb begin
        load_data = mem_rdata;
        case (size_q)
            2'd0:    load_data = {{24{signed_q & mem_rdata[0]}}, mem_rdata[0:7]};
            2'd1:    load_data = {{16{signed_q & mem_rdata[0]}}, mem_rdata[0:15]};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_next = req_error ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (wait_last) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_valid & resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The write strobe is derived from state so that an asynchronous reset
    // removes it immediately, even mid-cycle.
    assign mem_we = (state == ACCESS) & write_q & wait_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // req_ready is registered so it stays low while reset is held and
    // rises on the first clock edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            wait_cnt  <= 4'd0;
        end else begin
            req_ready <= (state_next == IDLE);
            if ((state == ACCESS) && !wait_last) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
        end
    end

    // Only accepted, well-formed requests move the memory port, so it keeps
    // its last values across error responses and idle time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q   <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= 2'd0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_dsize <= 2'd0;
        end else if (transfer) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            size_q   <= req_size;
            if (!req_error) begin
                mem_addr  <= req_addr;
                mem_wdata <= store_lane;
                mem_dsize <= req_size;
            end
        end
    end

    // A good request publishes its response on the edge that ends ACCESS.
    // An error enters RESP with resp_valid still low and publishes on the
    // following edge, so it too appears one edge after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else if ((state == ACCESS) && wait_last) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= write_q ? 32'h0 : load_data;
        end else if (state == RESP) begin
            if (!resp_valid) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
                resp_rdata <= 32'h0;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule
